access_count_monitor: RTL and testbench

ACCESS_COUNT_MONITOR -- requirements
Module: access_count_monitor

---
 rtl/access_count_monitor.sv | 162 ++++++++++++++++
 tb/tb_access_count_monitor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : access_count_monitor
//  Description : Per-port read/write access counters with saturation flags and
//                a ready/valid serial readout of all counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module access_count_monitor #(
    parameter int NUM_PORTS     = 16,
    parameter int CNT_WIDTH     = 32,
    parameter int CLEAR_ON_DUMP = 0
) (
    input  logic                              clk,
    input  logic                              arst_n_in,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [NUM_PORTS-1:0]              rd_strobe,
    input  logic [NUM_PORTS-1:0]              wr_strobe,
    input  logic                              dump_start,
    output logic [CNT_WIDTH-1:0]              dump_data,
    output logic [$clog2(2*NUM_PORTS)-1:0]    dump_index,
    output logic                              dump_valid,
    input  logic                              dump_ready,
    output logic                              dump_last,
    output logic                              busy,
    output logic [NUM_PORTS-1:0]              saturated
);

    localparam int                   IDX_W           = $clog2(2*NUM_PORTS);
    localparam logic [IDX_W-1:0]     c_last_idx      = IDX_W'(2*NUM_PORTS - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max       = '1;
    localparam bit                   c_clear_on_dump = (CLEAR_ON_DUMP != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_WIDTH-1:0]   r_rd_cnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   r_wr_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0]   r_sat;

    logic                   w_valid;
    logic                   w_accept;
    logic [NUM_PORTS-1:0]   w_rd_inc;
    logic [NUM_PORTS-1:0]   w_wr_inc;
    logic [NUM_PORTS-1:0]   w_rd_take;
    logic [NUM_PORTS-1:0]   w_wr_take;
    logic [CNT_WIDTH-1:0]   w_sel;

    assign w_valid  = (r_state == ST_DUMP);
    assign w_accept = w_valid & dump_ready;
    assign w_rd_inc = {NUM_PORTS{enable}} & rd_strobe;
    assign w_wr_inc = {NUM_PORTS{enable}} & wr_strobe;

    // Flag which counter (if any) is being handed off this cycle in clear-on-dump mode
    always_comb begin
        w_rd_take = '0;
        w_wr_take = '0;
        if (c_clear_on_dump && w_accept) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_rd_take[p] = (r_idx == IDX_W'(2*p));
                w_wr_take[p] = (r_idx == IDX_W'(2*p + 1));
            end
        end
    end

    // Dump sequencer: walk word indices 0..2*NUM_PORTS-1, advancing only on handshake
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        r_state <= ST_DUMP;
                        r_idx   <= '0;
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Saturating access counters; clear wins, then a readout hand-off restarts
    // the counter from this cycle's strobe so no access is lost
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rd_cnt[p] <= '0;
                r_wr_cnt[p] <= '0;
            end
            r_sat <= '0;
        end else if (clear) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rd_cnt[p] <= '0;
                r_wr_cnt[p] <= '0;
            end
            r_sat <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_rd_take[p]) begin
                    r_rd_cnt[p] <= CNT_WIDTH'(w_rd_inc[p]);
                end else if (w_rd_inc[p]) begin
                    if (r_rd_cnt[p] == c_cnt_max) begin
                        r_sat[p] <= 1'b1;
                    end else begin
                        r_rd_cnt[p] <= r_rd_cnt[p] + CNT_WIDTH'(1);
                    end
                end

                if (w_wr_take[p]) begin
                    r_wr_cnt[p] <= CNT_WIDTH'(w_wr_inc[p]);
                end else if (w_wr_inc[p]) begin
                    if (r_wr_cnt[p] == c_cnt_max) begin
                        r_sat[p] <= 1'b1;
                    end else begin
                        r_wr_cnt[p] <= r_wr_cnt[p] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Live select of the counter addressed by the registered index
    always_comb begin
        w_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_idx == IDX_W'(2*p)) begin
                w_sel = r_rd_cnt[p];
            end
            if (r_idx == IDX_W'(2*p + 1)) begin
                w_sel = r_wr_cnt[p];
            end
        end
    end

    assign dump_valid = w_valid;
    assign busy       = w_valid;
    assign dump_index = r_idx;
    assign dump_data  = w_valid ? w_sel : '0;
    assign dump_last  = w_valid & (r_idx == c_last_idx);
    assign saturated  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_access_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_access_count_monitor
//  Description : Directed + random bench for access_count_monitor; two DUTs
//                (readout non-destructive / clear-on-dump) share one stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_access_count_monitor;

    localparam int NP   = 2;
    localparam int CW   = 4;
    localparam int IW   = $clog2(2*NP);
    localparam int NW   = 2*NP;
    localparam int MAXV = 15;

    logic          clk        = 1'b0;
    logic          arst_n_in  = 1'b0;
    logic          enable     = 1'b0;
    logic          clear      = 1'b0;
    logic          dump_start = 1'b0;
    logic          dump_ready = 1'b0;
    logic [NP-1:0] rd_strobe  = '0;
    logic [NP-1:0] wr_strobe  = '0;

    logic [CW-1:0] dd  [2];
    logic [IW-1:0] di  [2];
    logic          dv  [2];
    logic          dl  [2];
    logic          bz  [2];
    logic [NP-1:0] sat [2];

    always #5 clk = ~clk;

    access_count_monitor #(.NUM_PORTS(NP), .CNT_WIDTH(CW), .CLEAR_ON_DUMP(0)) u_dut0 (
        .clk(clk), .arst_n_in(arst_n_in), .enable(enable), .clear(clear),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .dump_start(dump_start),
        .dump_data(dd[0]), .dump_index(di[0]), .dump_valid(dv[0]),
        .dump_ready(dump_ready), .dump_last(dl[0]), .busy(bz[0]), .saturated(sat[0])
    );

    access_count_monitor #(.NUM_PORTS(NP), .CNT_WIDTH(CW), .CLEAR_ON_DUMP(1)) u_dut1 (
        .clk(clk), .arst_n_in(arst_n_in), .enable(enable), .clear(clear),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .dump_start(dump_start),
        .dump_data(dd[1]), .dump_index(di[1]), .dump_valid(dv[1]),
        .dump_ready(dump_ready), .dump_last(dl[1]), .busy(bz[1]), .saturated(sat[1])
    );

    // Reference model: word list per DUT (word i = port i/2, even=read, odd=write)
    int unsigned   mw   [2][NW];
    bit [NP-1:0]   msat [2];
    bit            mbusy;
    int            midx;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NW; i++) mw[k][i] = 0;
            msat[k] = '0;
        end
        mbusy = 1'b0;
        midx  = 0;
    endtask

    // Apply the rules for one rising edge using the inputs currently driven
    task automatic model_edge();
        bit accept;
        int acc_i;
        accept = mbusy && dump_ready;
        acc_i  = midx;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NW; i++) begin
                int port;
                bit hit;
                port = i / 2;
                hit  = enable && ((i % 2 == 0) ? rd_strobe[port] : wr_strobe[port]);
                if (clear)                              mw[k][i] = 0;
                else if (k == 1 && accept && acc_i == i) mw[k][i] = hit ? 1 : 0;
                else if (hit) begin
                    if (mw[k][i] == MAXV) msat[k][port] = 1'b1;
                    else                  mw[k][i] = mw[k][i] + 1;
                end
            end
            if (clear) msat[k] = '0;
        end
        if (!mbusy) begin
            if (dump_start) begin
                mbusy = 1'b1;
                midx  = 0;
            end
        end else if (dump_ready) begin
            if (midx == NW - 1) begin
                mbusy = 1'b0;
                midx  = 0;
            end else begin
                midx = midx + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d.dump_valid", k), 32'(dv[k]),  32'(mbusy));
            chk($sformatf("dut%0d.busy", k),       32'(bz[k]),  32'(mbusy));
            chk($sformatf("dut%0d.dump_index", k), 32'(di[k]),  32'(midx));
            chk($sformatf("dut%0d.dump_data", k),  32'(dd[k]),  mbusy ? mw[k][midx] : 32'd0);
            chk($sformatf("dut%0d.dump_last", k),  32'(dl[k]),  32'(mbusy && midx == NW - 1));
            chk($sformatf("dut%0d.saturated", k),  32'(sat[k]), 32'(msat[k]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet_inputs();
        enable     = 1'b1;
        clear      = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        rd_strobe  = '0;
        wr_strobe  = '0;
    endtask

    initial begin
        int ready_pat [6];
        int idx_exp   [6];
        ready_pat = '{1, 0, 0, 1, 1, 1};
        idx_exp   = '{1, 1, 1, 2, 3, 0};

        // Reset state, held across an edge
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #3 arst_n_in = 1'b1;
        quiet_inputs();

        // Basic dump: rd[0] x5, wr[1] x3 -> 5,0,0,3
        rd_strobe = 2'b01;
        repeat (5) step();
        rd_strobe = 2'b00;
        wr_strobe = 2'b10;
        repeat (3) step();
        wr_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        chk("A.word0", 32'(dd[0]), 32'd5);
        chk("A.word0_cod", 32'(dd[1]), 32'd5);
        step();
        chk("A.word1", 32'(dd[0]), 32'd0);
        step();
        chk("A.word2", 32'(dd[0]), 32'd0);
        step();
        chk("A.word3", 32'(dd[0]), 32'd3);
        chk("A.last3", 32'(dl[0]), 32'd1);
        step();
        chk("A.busy_after", 32'(bz[0]), 32'd0);
        dump_ready = 1'b0;

        // Saturation of a 4-bit counter
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd_strobe = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) chk("B.sat_at15", 32'(sat[0]), 32'd0);
            if (i == 16) chk("B.sat_at16", 32'(sat[0]), 32'd1);
        end
        rd_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("B.rd0_sat_value", 32'(dd[0]), 32'd15);
        chk("B.sat_bits", 32'(sat[1]), 32'd1);
        dump_ready = 1'b1;
        repeat (4) step();
        dump_ready = 1'b0;

        // Clear beats a simultaneous strobe and clears saturation
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd_strobe = 2'b01;
        wr_strobe = 2'b01;
        repeat (9) step();
        rd_strobe = 2'b00;
        repeat (7) step();
        wr_strobe = 2'b00;
        chk("C.sat_before_clear", 32'(sat[0]), 32'd1);
        clear = 1'b1;
        rd_strobe = 2'b01;
        step();
        clear = 1'b0;
        rd_strobe = 2'b00;
        chk("C.sat_after_clear", 32'(sat[0]), 32'd0);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("C.rd0_after_clear", 32'(dd[0]), 32'd0);
        dump_ready = 1'b1;
        repeat (4) step();
        dump_ready = 1'b0;

        // Back-pressure: ready 1,0,0,1,1,1
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd_strobe = 2'b01;
        wr_strobe = 2'b10;
        repeat (2) step();
        rd_strobe = 2'b10;
        wr_strobe = 2'b00;
        step();
        rd_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dump_ready = ready_pat[i][0];
            step();
            chk($sformatf("D.index_step%0d", i), 32'(di[0]), 32'(idx_exp[i]));
        end
        dump_ready = 1'b0;

        // Clear-on-dump with a strobe on the hand-off cycle
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd_strobe = 2'b01;
        repeat (7) step();
        rd_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("E.rd0_before", 32'(dd[1]), 32'd7);
        dump_ready = 1'b1;
        rd_strobe = 2'b01;
        step();
        rd_strobe = 2'b00;
        repeat (3) step();
        dump_ready = 1'b0;
        rd_strobe = 2'b01;
        repeat (2) step();
        rd_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("E.rd0_cod", 32'(dd[1]), 32'd3);
        chk("E.rd0_nocod", 32'(dd[0]), 32'd10);
        dump_ready = 1'b1;
        repeat (4) step();
        dump_ready = 1'b0;

        // Asynchronous reset in the middle of a dump
        rd_strobe = 2'b01;
        wr_strobe = 2'b11;
        repeat (3) step();
        rd_strobe = 2'b00;
        wr_strobe = 2'b00;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (2) step();
        dump_ready = 1'b0;
        chk("F.index_before_rst", 32'(di[0]), 32'd2);
        #2 arst_n_in = 1'b0;
        #1;
        model_reset();
        chk("F.valid_in_rst", 32'(dv[0]), 32'd0);
        chk("F.data_in_rst", 32'(dd[1]), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2 arst_n_in = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("F.restart_index", 32'(di[0]), 32'd0);
        dump_ready = 1'b1;
        repeat (4) step();
        dump_ready = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            enable     = ($urandom % 4) != 0;
            rd_strobe  = NP'($urandom);
            wr_strobe  = NP'($urandom);
            clear      = ($urandom % 40) == 0;
            dump_start = ($urandom % 8) == 0;
            dump_ready = ($urandom % 3) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
